// File: rtl/mux_pkg.sv
// Shared constants for the arbitrated multiplexer family.
// MODE selects the arbitration policy used by rr_grant and rr_arb_mux.
package mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

endpackage

// File: rtl/rr_grant.sv
// Combinational grant logic: round-robin from last_grant+1, or fixed lowest-index priority.
// Works on a doubled request vector so the wrap past CHANNELS-1 needs no modulo hardware.
module rr_grant
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_RR,
    localparam int CHAN_W  = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [CHAN_W-1:0]   last_grant,
    output logic [CHANNELS-1:0] grant,
    output logic [CHAN_W-1:0]   index
);

    logic [CHAN_W-1:0]     rr_start_s;
    logic [CHAN_W-1:0]     start_s;
    logic [2*CHANNELS-1:0] mask_s;
    logic [2*CHANNELS-1:0] masked_s;
    logic                  found_s;

    // Search start position; explicit compare keeps the wrap correct for non-power-of-2 CHANNELS
    always_comb begin
        if (last_grant >= CHAN_W'(CHANNELS - 1)) begin
            rr_start_s = '0;
        end else begin
            rr_start_s = last_grant + CHAN_W'(1);
        end
        if (MODE == MODE_FIXED) begin
            start_s = '0;
        end else begin
            start_s = rr_start_s;
        end
    end

    // Mask off positions below start in the lower copy; the upper copy supplies the wrapped requests
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < 2 * CHANNELS; i++) begin
            mask_s[i] = (i >= int'(start_s));
        end
        masked_s = {req, req} & mask_s;
    end

    // Lowest set bit of the masked vector, folded back into the channel range
    always_comb begin
        found_s = 1'b0;
        index   = '0;
        grant   = '0;
        for (int i = 0; i < 2 * CHANNELS; i++) begin
            if (!found_s && masked_s[i]) begin
                found_s = 1'b1;
                if (i >= CHANNELS) begin
                    index = CHAN_W'(i - CHANNELS);
                end else begin
                    index = CHAN_W'(i);
                end
            end else begin
                found_s = found_s;
            end
        end
        grant[index] = found_s;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// CHANNELS-way arbitrated multiplexer with valid/ready flow control and one registered output stage.
// The output register reloads whenever it is empty or being drained in the same cycle.
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int N        = 1,
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_RR,
    localparam int CHAN_W  = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   in_valid,
    input  logic [CHANNELS*N-1:0] in_data,
    output logic [CHANNELS-1:0]   in_ready,
    output logic                  out_valid,
    output logic [N-1:0]          out_data,
    output logic [CHAN_W-1:0]     out_chan,
    input  logic                  out_ready
);

    logic [CHAN_W-1:0]   last_grant_r;
    logic [CHANNELS-1:0] grant_s;
    logic [CHAN_W-1:0]   grant_idx_s;
    logic [N-1:0]        sel_data_s;
    logic                load_en_s;
    logic                any_valid_s;

    rr_grant #(
        .CHANNELS (CHANNELS),
        .MODE     (MODE)
    ) u_grant (
        .req        (in_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .index      (grant_idx_s)
    );

    assign load_en_s   = !out_valid || out_ready;
    assign any_valid_s = |in_valid;
    assign in_ready    = grant_s & {CHANNELS{load_en_s}};

    // Indexed data select of the granted channel
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx_s == CHAN_W'(i)) begin
                sel_data_s = in_data[i*N +: N];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Output register and arbitration pointer; a stall holds everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_chan     <= '0;
            last_grant_r <= CHAN_W'(CHANNELS - 1);
        end else if (load_en_s) begin
            if (any_valid_s) begin
                out_valid <= 1'b1;
                out_data  <= sel_data_s;
                out_chan  <= grant_idx_s;
                if (MODE == MODE_RR) begin
                    last_grant_r <= grant_idx_s;
                end else begin
                    last_grant_r <= last_grant_r;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed vector tables on three configurations,
// then constrained-random traffic compared against a rotating-pointer reference model.
module tb_rr_arb_mux;

    typedef struct {
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_ir;
        logic       exp_ov;
        logic [1:0] exp_chan;
        logic [7:0] exp_data;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [3:0]  v4, ir4, vf, irf;
    logic [31:0] d4, df;
    logic        r4, ov4, rf, ovf, r3, ov3;
    logic [7:0]  od4, odf, od3;
    logic [1:0]  oc4, ocf, oc3;
    logic [2:0]  v3, ir3;
    logic [23:0] d3;

    int vectors;
    int miscompares;

    int         nch   [3];
    int         md    [3];
    logic [3:0] s_valid [3];
    logic [7:0] s_data  [3][4];
    logic       s_ordy  [3];
    logic       m_ov  [3];
    logic [7:0] m_od  [3];
    int         m_oc  [3];
    int         m_ptr [3];

    vec_t t2 [13];
    vec_t t4 [6];
    vec_t t5 [5];
    vec_t tr [4];

    rr_arb_mux #(.N(8), .CHANNELS(4), .MODE(0)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(ir4),
        .out_valid(ov4), .out_data(od4), .out_chan(oc4), .out_ready(r4));

    rr_arb_mux #(.N(8), .CHANNELS(3), .MODE(0)) u3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .in_ready(ir3),
        .out_valid(ov3), .out_data(od3), .out_chan(oc3), .out_ready(r3));

    rr_arb_mux #(.N(8), .CHANNELS(4), .MODE(1)) uf (
        .clk(clk), .rst(rst), .in_valid(vf), .in_data(df), .in_ready(irf),
        .out_valid(ovf), .out_data(odf), .out_chan(ocf), .out_ready(rf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic get_dut(input int k, output logic ov, output logic [7:0] od,
                           output logic [1:0] oc, output logic [3:0] ir);
        case (k)
            0:       begin ov = ov4; od = od4; oc = oc4; ir = ir4; end
            1:       begin ov = ov3; od = od3; oc = oc3; ir = {1'b0, ir3}; end
            default: begin ov = ovf; od = odf; oc = ocf; ir = irf; end
        endcase
    endtask

    // One directed vector: check in_ready before the edge, registered outputs after it
    task automatic run_vec(input int k, input vec_t v, input string tag);
        logic ov; logic [7:0] od; logic [1:0] oc; logic [3:0] ir;
        case (k)
            0:       begin v4 = v.valid; r4 = v.ordy; end
            1:       begin v3 = v.valid[2:0]; r3 = v.ordy; end
            default: begin vf = v.valid; rf = v.ordy; end
        endcase
        #2;
        get_dut(k, ov, od, oc, ir);
        chk({tag, " in_ready"}, {28'd0, ir}, {28'd0, v.exp_ir});
        @(negedge clk);
        get_dut(k, ov, od, oc, ir);
        chk({tag, " out_valid"}, {31'd0, ov}, {31'd0, v.exp_ov});
        chk({tag, " out_chan"}, {30'd0, oc}, {30'd0, v.exp_chan});
        chk({tag, " out_data"}, {24'd0, od}, {24'd0, v.exp_data});
    endtask

    function automatic int ref_grant(input int k);
        for (int s = 0; s < nch[k]; s++) begin
            int c;
            c = (md[k] == 1) ? s : (m_ptr[k] + 1 + s) % nch[k];
            if (s_valid[k][c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ov[k] = 1'b0; m_od[k] = 8'd0; m_oc[k] = 0; m_ptr[k] = nch[k] - 1;
            s_valid[k] = 4'd0; s_ordy[k] = 1'b1;
            for (int c = 0; c < 4; c++) s_data[k][c] = 8'd0;
        end
    endtask

    task automatic apply();
        v4 = s_valid[0]; v3 = s_valid[1][2:0]; vf = s_valid[2];
        r4 = s_ordy[0];  r3 = s_ordy[1];       rf = s_ordy[2];
        for (int i = 0; i < 4; i++) begin
            d4[i*8 +: 8] = s_data[0][i];
            df[i*8 +: 8] = s_data[2][i];
        end
        for (int i = 0; i < 3; i++) d3[i*8 +: 8] = s_data[1][i];
    endtask

    // One random cycle on all three instances against the reference model
    task automatic rand_cycle();
        logic [3:0] acc [3];
        logic ov; logic [7:0] od; logic [1:0] oc; logic [3:0] ir;
        apply();
        #2;
        for (int k = 0; k < 3; k++) begin
            int   g;
            logic load;
            g    = ref_grant(k);
            load = !m_ov[k] || s_ordy[k];
            acc[k] = (load && g >= 0) ? (4'b0001 << g) : 4'b0000;
            get_dut(k, ov, od, oc, ir);
            chk($sformatf("rand%0d in_ready", k), {28'd0, ir}, {28'd0, acc[k]});
            chk($sformatf("rand%0d out_valid", k), {31'd0, ov}, {31'd0, m_ov[k]});
            chk($sformatf("rand%0d out_chan", k), {30'd0, oc}, m_oc[k]);
            chk($sformatf("rand%0d out_data", k), {24'd0, od}, {24'd0, m_od[k]});
            if (load) begin
                if (g >= 0) begin
                    m_ov[k] = 1'b1; m_od[k] = s_data[k][g]; m_oc[k] = g;
                    if (md[k] == 0) m_ptr[k] = g;
                end else begin
                    m_ov[k] = 1'b0;
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < nch[k]; c++) begin
                if (!(s_valid[k][c] && !acc[k][c])) begin
                    s_valid[k][c] = ($urandom_range(0, 3) != 0);
                    s_data[k][c]  = 8'($urandom);
                end
            end
            s_ordy[k] = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        nch = '{4, 3, 4};
        md  = '{0, 0, 1};
        rst = 1'b1;
        v4 = 4'd0; v3 = 3'd0; vf = 4'd0;
        r4 = 1'b1; r3 = 1'b1; rf = 1'b1;
        d4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        d3 = {8'hC2, 8'hC1, 8'hC0};
        df = {8'hB3, 8'hB2, 8'hB1, 8'hB0};

        // Fairness, backpressure and idle drain on the 4-channel round-robin instance
        t2[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        t2[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        t2[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
        t2[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        t2[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        t2[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        t2[6]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
        t2[7]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
        t2[8]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd1, 8'hA1};
        t2[9]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
        t2[10] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2};
        t2[11] = '{4'h0, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2};
        t2[12] = '{4'h0, 1'b0, 4'b0000, 1'b0, 2'd2, 8'hA2};

        tr[0]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        tr[1]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        tr[2]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0};
        tr[3]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};

        // Sparse requests and wrap on the 3-channel instance
        t4[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2};
        t4[1]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hC0};
        t4[2]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hC1};
        t4[3]  = '{4'b0111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hC2};
        t4[4]  = '{4'b0111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hC0};
        t4[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hC0};

        // Fixed priority: ch1 starves ch3 until it drops
        t5[0]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};
        t5[1]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};
        t5[2]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};
        t5[3]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hB3};
        t5[4]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hB1};

        repeat (2) @(negedge clk);
        #1;
        chk("reset out_valid", {31'd0, ov4}, 32'd0);
        chk("reset out_chan", {30'd0, oc4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(0, t2[i], $sformatf("rr4[%0d]", i));

        for (int i = 0; i < 3; i++) run_vec(0, tr[i], $sformatf("pre_rst[%0d]", i));
        #1 rst = 1'b1;
        #1;
        chk("async rst out_valid", {31'd0, ov4}, 32'd0);
        chk("async rst out_chan", {30'd0, oc4}, 32'd0);
        chk("async rst out_data", {24'd0, od4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(0, tr[3], "post_rst");
        v4 = 4'd0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(1, t4[i], $sformatf("wrap3[%0d]", i));
        for (int i = 0; i < 5; i++) run_vec(2, t5[i], $sformatf("fixed[%0d]", i));

        rst = 1'b1;
        model_reset();
        apply();
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 400; n++) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
